alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 182 ++++++++++++++++++
 tb/tb_alu_seq.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential WIDTH-bit ALU with valid/ready handshake on both sides.
// Single-cycle ops finish in one clock; shifts iterate one bit per cycle and
// MUL runs a WIDTH-step shift-and-add in the BUSY state.
// Optional feature macro: ALU_SEQ_MUL_EN (defined: opcode 1010 is MUL;
// undefined: no multiplier is built and 1010 decodes as illegal).
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   command handshake; operands latched on accept
//   alu_cmd, inA, inB   opcode and operands (inA[SHW-1:0] = shift amount)
//   sc_i                shift fill bit / add carry-in
//   out_valid/out_ready result handshake; result held until taken
//   rslt                registered result
//   sc_o                carry / borrow / last bit shifted out / MUL overflow
//   pari, zero          parity and zero of rslt (only while out_valid)
//   branch_bool         BNE taken
//   illegal             unsupported opcode
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_cmd,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             sc_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rslt,
  output logic             sc_o,
  output logic             pari,
  output logic             zero,
  output logic             branch_bool,
  output logic             illegal
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_XOR   = 4'b0010;
  localparam logic [3:0] OP_BNE   = 4'b0011;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0101;
  localparam logic [3:0] OP_LSL   = 4'b0110;
  localparam logic [3:0] OP_LSR   = 4'b0111;
  localparam logic [3:0] OP_LOADI = 4'b1000;
  localparam logic [3:0] OP_PARI  = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_NOP   = 4'b1111;
  localparam logic [SHW-1:0] W_N  = SHW'(WIDTH);
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  logic [1:0]       r_state;
  logic [3:0]       r_cmd;
  logic             r_fill;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_rslt;
  logic             r_sc;
  logic             r_bb;
  logic             r_ill;
  logic             w_acc;
  logic             w_ne;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [SHW-1:0]   w_n;
  logic             w_multi;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_bb;
  logic             w_ill;
  logic [WIDTH-1:0] w_lo_nx;
  logic             w_out;
  assign in_ready    = rst_n && (r_state == S_IDLE || (r_state == S_DONE && out_ready));
  assign w_acc       = in_valid && in_ready;
  assign out_valid   = r_state == S_DONE;
  assign rslt        = r_rslt;
  assign sc_o        = r_sc;
  assign branch_bool = r_bb;
  assign illegal     = r_ill;
  // Gated by out_valid so they read 0 in reset and never reflect a stale value.
  assign pari        = out_valid && ^r_rslt;
  assign zero        = out_valid && ~|r_rslt;
  assign w_ne  = inA != inB;
  assign w_add = {1'b0, inA} + {1'b0, inB} + {{WIDTH{1'b0}}, sc_i};
  assign w_sub = {1'b0, inA} - {1'b0, inB};
  // Shift count saturates at WIDTH: more steps would only repeat the fill bit.
  assign w_n   = inA[SHW-1:0] > W_N ? W_N : inA[SHW-1:0];
  assign w_multi = ((alu_cmd == OP_LSL || alu_cmd == OP_LSR) && w_n != '0) ||
                   (MUL_EN && alu_cmd == OP_MUL);
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_bb  = 1'b0;
    w_ill = 1'b0;
    case (alu_cmd)
      OP_LOAD, OP_STORE, OP_NOP: w_res = inA;
      OP_XOR:   w_res = inA ^ inB;
      OP_BNE: begin
        w_res = {{(WIDTH-1){1'b0}}, w_ne};
        w_bb  = w_ne;
      end
      OP_ADD:   {w_c, w_res} = w_add;
      OP_SUB:   {w_c, w_res} = w_sub;
      OP_LSL, OP_LSR, OP_LOADI: w_res = inB;
      OP_PARI:  w_res = {{(WIDTH-1){1'b0}}, ^inA};
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:   w_res = '0;
`endif
      default:  w_ill = 1'b1;
    endcase
  end
`ifdef ALU_SEQ_MUL_EN
  // Product lives in {r_hi, r_lo}; r_lo starts as the multiplier and is
  // consumed LSB-first while the partial product shifts in from the top.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_hi_nx;
  logic [WIDTH-1:0] w_mlo_nx;
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign {w_hi_nx, w_mlo_nx} = {w_sum, r_lo[WIDTH-1:1]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= '0;
      r_hi <= '0;
    end else if (w_acc) begin
      r_a  <= inA;
      r_hi <= '0;
    end else if (r_state == S_BUSY) begin
      r_hi <= w_hi_nx;
    end
  end
`endif
  always_comb begin
    w_lo_nx = r_cmd == OP_LSL ? {r_lo[WIDTH-2:0], r_fill} : {r_fill, r_lo[WIDTH-1:1]};
    w_out   = r_cmd == OP_LSL ? r_lo[WIDTH-1] : r_lo[0];
`ifdef ALU_SEQ_MUL_EN
    w_lo_nx = r_cmd == OP_MUL ? w_mlo_nx : w_lo_nx;
    w_out   = r_cmd == OP_MUL ? |w_hi_nx : w_out;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cmd   <= '0;
      r_fill  <= 1'b0;
      r_cnt   <= '0;
      r_lo    <= '0;
      r_rslt  <= '0;
      r_sc    <= 1'b0;
      r_bb    <= 1'b0;
      r_ill   <= 1'b0;
    end else if (w_acc) begin
      r_state <= w_multi ? S_BUSY : S_DONE;
      r_cmd   <= alu_cmd;
      r_fill  <= sc_i;
      r_cnt   <= alu_cmd == OP_MUL ? W_N : w_n;
      r_lo    <= inB;
      r_rslt  <= w_res;
      r_sc    <= w_c;
      r_bb    <= w_bb;
      r_ill   <= w_ill;
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt - 1'b1;
      r_lo  <= w_lo_nx;
      if (r_cnt == SHW'(1)) begin
        r_state <= S_DONE;
        r_rslt  <= w_lo_nx;
        r_sc    <= w_out;
      end
    end else if (r_state == S_DONE && out_ready) begin
      r_state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=8).
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       sc_i = 1'b0;
  logic [3:0] alu_cmd = 4'h0;
  logic [7:0] inA = 8'h00;
  logic [7:0] inB = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] rslt;
  logic       sc_o;
  logic       pari;
  logic       zero;
  logic       branch_bool;
  logic       illegal;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_cmd(alu_cmd), .inA(inA), .inB(inB), .sc_i(sc_i),
    .out_valid(out_valid), .out_ready(out_ready), .rslt(rslt), .sc_o(sc_o),
    .pari(pari), .zero(zero), .branch_bool(branch_bool), .illegal(illegal)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input string tag, input logic [3:0] c, input logic [7:0] a,
                     input logic [7:0] b, input logic s, input int lat,
                     input logic [7:0] r, input logic co, input logic bb, input logic ill);
    int k;
    check({tag, " in_ready"}, in_ready, 1);
    alu_cmd = c; inA = a; inB = b; sc_i = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; alu_cmd = 4'hF; inA = ~a; inB = ~b; sc_i = ~s;
    k = 1;
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
    check({tag, " latency"}, k, lat);
    check({tag, " rslt"}, rslt, r);
    check({tag, " sc_o"}, sc_o, co);
    check({tag, " branch_bool"}, branch_bool, bb);
    check({tag, " illegal"}, illegal, ill);
    check({tag, " zero"}, zero, r == 8'h00);
    check({tag, " pari"}, pari, ^r);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " drained"}, out_valid, 0);
  endtask
  initial begin
    #12;
    check("rst in_ready", in_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst rslt", rslt, 0);
    check("rst flags", {sc_o, pari, zero, branch_bool, illegal}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-rst in_ready", in_ready, 1);
    run("add_carry", 4'h4, 8'hF0, 8'h20, 1'b0, 1, 8'h10, 1'b1, 1'b0, 1'b0);
    run("lsl3",      4'h6, 8'h03, 8'hA1, 1'b0, 4, 8'h08, 1'b1, 1'b0, 1'b0);
    run("lsr_clamp", 4'h7, 8'h09, 8'h80, 1'b1, 9, 8'hFF, 1'b1, 1'b0, 1'b0);
    run("lsl0",      4'h6, 8'h10, 8'h3C, 1'b1, 1, 8'h3C, 1'b0, 1'b0, 1'b0);
    run("sub_borrow",4'h5, 8'h10, 8'h20, 1'b1, 1, 8'hF0, 1'b1, 1'b0, 1'b0);
    run("add_cin",   4'h4, 8'hFF, 8'h00, 1'b1, 1, 8'h00, 1'b1, 1'b0, 1'b0);
    run("pari",      4'h9, 8'h07, 8'h00, 1'b0, 1, 8'h01, 1'b0, 1'b0, 1'b0);
    run("load",      4'h0, 8'h81, 8'h22, 1'b0, 1, 8'h81, 1'b0, 1'b0, 1'b0);
    run("loadi",     4'h8, 8'h81, 8'h5A, 1'b0, 1, 8'h5A, 1'b0, 1'b0, 1'b0);
    run("bne_eq",    4'h3, 8'h33, 8'h33, 1'b0, 1, 8'h00, 1'b0, 1'b0, 1'b0);
    run("bne_ne",    4'h3, 8'h33, 8'h34, 1'b0, 1, 8'h01, 1'b0, 1'b1, 1'b0);
    run("illegal_c", 4'hC, 8'h12, 8'h34, 1'b1, 1, 8'h00, 1'b0, 1'b0, 1'b1);
`ifdef ALU_SEQ_MUL_EN
    run("mul_small", 4'hA, 8'h0D, 8'h0B, 1'b0, 9, 8'h8F, 1'b0, 1'b0, 1'b0);
    run("mul_ovf",   4'hA, 8'h20, 8'h10, 1'b0, 9, 8'h00, 1'b1, 1'b0, 1'b0);
`else
    run("mul_off",   4'hA, 8'h0D, 8'h0B, 1'b0, 1, 8'h00, 1'b0, 1'b0, 1'b1);
`endif
    alu_cmd = 4'h2; inA = 8'hA5; inB = 8'h0F; sc_i = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; inA = 8'h00; inB = 8'h00;
    check("bp out_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp hold rslt", rslt, 8'hAA);
      check("bp hold flags", {sc_o, pari, zero, branch_bool, illegal}, 0);
      check("bp in_ready", in_ready, 0);
      check("bp hold valid", out_valid, 1);
    end
    alu_cmd = 4'h4; inA = 8'h01; inB = 8'h01; sc_i = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("b2b in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b out_valid", out_valid, 1);
    check("b2b rslt", rslt, 8'h02);
    check("b2b flags", {sc_o, zero, illegal}, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    alu_cmd = 4'hA; inA = 8'h0D; inB = 8'h0B;
`else
    alu_cmd = 4'h7; inA = 8'h08; inB = 8'h80;
`endif
    sc_i = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("abort busy in_ready", in_ready, 0);
    check("abort busy valid", out_valid, 0);
    tick();
    rst_n = 1'b0;
    #1;
    check("abort in_ready", in_ready, 0);
    check("abort out_valid", out_valid, 0);
    check("abort rslt", rslt, 0);
    check("abort flags", {sc_o, pari, zero, branch_bool, illegal}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release in_ready", in_ready, 1);
    repeat (12) tick();
    check("discarded result", out_valid, 0);
    run("loadi_after", 4'h8, 8'h00, 8'h5A, 1'b0, 1, 8'h5A, 1'b0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
